// File: rtl/mem_init_pkg.sv
// mem_init_pkg: shared channel state encoding and counter sizing
// for the EMIF initialisation sequencer.
package mem_init_pkg;
  localparam int ST_W = 2;
  localparam int RC_W = 2;
  typedef enum logic [ST_W-1:0] {
    RST_HOLD = 2'd0,
    WAIT_CAL = 2'd1,
    READY    = 2'd2,
    ERROR    = 2'd3
  } emif_init_state_t;
  function automatic int cw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/emif_ch_init_fsm.sv
// emif_ch_init_fsm: one channel's reset-hold / calibration-wait sequencer.
// The WAIT_CAL timeout counter exists only when EMIF_INIT_TIMEOUT_EN is defined.
module emif_ch_init_fsm
  import mem_init_pkg::*;
#(
  parameter int RESET_HOLD  = 16,
  parameter int CAL_TIMEOUT = 1000000,
  parameter int MAX_RETRY   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_cal_success,
  input  logic            i_cal_fail,
  input  logic            i_sw_reinit,
  output logic            o_rst_req,
  output logic            o_ready,
  output logic            o_error,
  output logic [ST_W-1:0] o_state,
  output logic [RC_W-1:0] o_retry
);
  localparam int HW = cw(RESET_HOLD);
  localparam int RW = cw(MAX_RETRY + 1);
  emif_init_state_t r_state, w_next;
  logic [HW-1:0] r_hcnt;
  logic [RW-1:0] r_retry, w_retry;
  logic r_rst_req, r_ready, r_error;
  logic w_rst_req, w_ready, w_error;
  logic w_to, w_fail, w_can_retry, w_clr;
  // Any state entry, including a reinit that re-enters RST_HOLD, restarts the counters.
  assign w_clr = i_sw_reinit || w_next != r_state;
`ifdef EMIF_INIT_TIMEOUT_EN
  localparam int TW = cw(CAL_TIMEOUT);
  logic [TW-1:0] r_tcnt;
  always_ff @(posedge clk)
    if (reset || w_clr) r_tcnt <= '0;
    else if (r_state == WAIT_CAL) r_tcnt <= r_tcnt + TW'(1);
  assign w_to = r_state == WAIT_CAL && r_tcnt == TW'(CAL_TIMEOUT - 1);
`else
  logic w_unused_to;
  assign w_unused_to = ^CAL_TIMEOUT;
  assign w_to = 1'b0;
`endif
  // Fail beats success; success beats a coincident timeout.
  assign w_fail      = i_cal_fail || (w_to && !i_cal_success);
  assign w_can_retry = r_retry < RW'(MAX_RETRY);
  always_ff @(posedge clk)
    if (reset) begin
      r_state   <= RST_HOLD;
      r_hcnt    <= '0;
      r_retry   <= '0;
      r_rst_req <= 1'b1;
      r_ready   <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_hcnt    <= w_clr ? '0 : r_hcnt + HW'(r_state == RST_HOLD);
      r_retry   <= w_retry;
      r_rst_req <= w_rst_req;
      r_ready   <= w_ready;
      r_error   <= w_error;
    end
  always_comb begin
    w_next  = r_state;
    w_retry = r_retry;
    if (i_sw_reinit) begin
      w_next  = RST_HOLD;
      w_retry = '0;
    end else if (r_state == RST_HOLD) begin
      w_next = r_hcnt == HW'(RESET_HOLD - 1) ? WAIT_CAL : RST_HOLD;
    end else if (r_state == WAIT_CAL && w_fail) begin
      w_next  = w_can_retry ? RST_HOLD : ERROR;
      w_retry = w_can_retry ? r_retry + RW'(1) : r_retry;
    end else if (r_state == WAIT_CAL && i_cal_success) begin
      w_next = READY;
    end else if (r_state == READY && !i_cal_success) begin
      w_next  = RST_HOLD;
      w_retry = '0;
    end
  end
  always_comb begin
    w_rst_req = w_next == RST_HOLD;
    w_ready   = w_next == READY;
    w_error   = w_next == ERROR;
  end
  assign o_rst_req = r_rst_req;
  assign o_ready   = r_ready;
  assign o_error   = r_error;
  assign o_state   = r_state;
  assign o_retry   = RC_W'(r_retry);
endmodule

// File: rtl/emif_init_seq.sv
// emif_init_seq: NUM_CH independent EMIF init sequencers plus ready/error reductions.
// Define EMIF_INIT_TIMEOUT_EN to enable the WAIT_CAL timeout.
module emif_init_seq
  import mem_init_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int RESET_HOLD  = 16,
  parameter int CAL_TIMEOUT = 1000000,
  parameter int MAX_RETRY   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CH-1:0]      cal_success,
  input  logic [NUM_CH-1:0]      cal_fail,
  input  logic [NUM_CH-1:0]      sw_reinit,
  output logic [NUM_CH-1:0]      emif_rst_req,
  output logic [NUM_CH-1:0]      ch_ready,
  output logic [NUM_CH-1:0]      ch_error,
  output logic [ST_W*NUM_CH-1:0] ch_state,
  output logic [RC_W*NUM_CH-1:0] retry_cnt,
  output logic                   all_ready,
  output logic                   any_error
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    emif_ch_init_fsm #(
      .RESET_HOLD (RESET_HOLD),
      .CAL_TIMEOUT(CAL_TIMEOUT),
      .MAX_RETRY  (MAX_RETRY)
    ) u_fsm (
      .clk          (clk),
      .reset        (reset),
      .i_cal_success(cal_success[i]),
      .i_cal_fail   (cal_fail[i]),
      .i_sw_reinit  (sw_reinit[i]),
      .o_rst_req    (emif_rst_req[i]),
      .o_ready      (ch_ready[i]),
      .o_error      (ch_error[i]),
      .o_state      (ch_state[ST_W*i +: ST_W]),
      .o_retry      (retry_cnt[RC_W*i +: RC_W])
    );
  end
  assign all_ready = &ch_ready;
  assign any_error = |ch_error;
endmodule

// File: tb/tb_emif_init_seq.sv
// tb_emif_init_seq: directed scenarios plus randomized run against a phase/age model.
module tb_emif_init_seq;
  localparam int N = 4, RH = 16, CT = 100, MR = 2;
`ifdef EMIF_INIT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] cal_success = '0, cal_fail = '0, sw_reinit = '0;
  logic [N-1:0] emif_rst_req, ch_ready, ch_error;
  logic [2*N-1:0] ch_state, retry_cnt;
  logic all_ready, any_error;
  int n_chk = 0, n_pass = 0;
  // Model: phase 0 hold, 1 waiting for calibration, 2 ready, 3 error; age = cycles already spent in phase.
  int m_ph[N], m_age[N], m_try[N];

  emif_init_seq #(.NUM_CH(N), .RESET_HOLD(RH), .CAL_TIMEOUT(CT), .MAX_RETRY(MR)) dut (
    .clk(clk), .reset(reset), .cal_success(cal_success), .cal_fail(cal_fail), .sw_reinit(sw_reinit),
    .emif_rst_req(emif_rst_req), .ch_ready(ch_ready), .ch_error(ch_error), .ch_state(ch_state),
    .retry_cnt(retry_cnt), .all_ready(all_ready), .any_error(any_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    for (int c = 0; c < N; c++) begin
      bit timed_out, fail;
      timed_out = TO_EN && m_ph[c] == 1 && m_age[c] == CT - 1;
      fail = cal_fail[c] || (timed_out && !cal_success[c]);
      if (reset || sw_reinit[c]) begin
        m_ph[c] = 0; m_age[c] = 0; m_try[c] = 0;
      end else if (m_ph[c] == 0 && m_age[c] == RH - 1) begin
        m_ph[c] = 1; m_age[c] = 0;
      end else if (m_ph[c] == 1 && fail) begin
        if (m_try[c] < MR) begin m_try[c]++; m_ph[c] = 0; end
        else m_ph[c] = 3;
        m_age[c] = 0;
      end else if (m_ph[c] == 1 && cal_success[c]) begin
        m_ph[c] = 2; m_age[c] = 0;
      end else if (m_ph[c] == 2 && !cal_success[c]) begin
        m_ph[c] = 0; m_age[c] = 0; m_try[c] = 0;
      end else m_age[c]++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    cal_success = '0; cal_fail = '0; sw_reinit = '0;
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic wait_st(input int c, input int s, input int lim, input string nm);
    int k = 0;
    while (ch_state[2*c +: 2] != 2'(s) && k < lim) begin tick(); k++; end
    if (ch_state[2*c +: 2] != 2'(s)) begin
      n_chk++;
      $display("FAIL %s: timed out with ch%0d state %0d, want %0d", nm, c, ch_state[2*c +: 2], s);
    end
  endtask

  task automatic test_reset();
    int n = 0;
    reset = 1'b1; tick(); tick();
    n_chk++; if (emif_rst_req !== 4'hF) $display("FAIL rst_req: got %h want f", emif_rst_req); else n_pass++;
    n_chk++; if (ch_ready !== 4'h0) $display("FAIL rst_ready: got %h want 0", ch_ready); else n_pass++;
    n_chk++; if (ch_error !== 4'h0) $display("FAIL rst_error: got %h want 0", ch_error); else n_pass++;
    n_chk++; if (all_ready !== 1'b0) $display("FAIL rst_all_ready: got %b want 0", all_ready); else n_pass++;
    n_chk++; if (any_error !== 1'b0) $display("FAIL rst_any_error: got %b want 0", any_error); else n_pass++;
    n_chk++; if (ch_state !== 8'h00) $display("FAIL rst_state: got %h want 00", ch_state); else n_pass++;
    n_chk++; if (retry_cnt !== 8'h00) $display("FAIL rst_retry: got %h want 00", retry_cnt); else n_pass++;
    reset = 1'b0; repeat (8) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    while (emif_rst_req[0] && n < 100) begin n++; tick(); end
    n_chk++; if (n != RH) $display("FAIL midreset_hold: got %0d cycles want %0d", n, RH); else n_pass++;
    n_chk++; if (ch_state[1:0] !== 2'd1) $display("FAIL midreset_wait: got %0d want 1", ch_state[1:0]); else n_pass++;
  endtask

  task automatic test_cal_success();
    int n = 0;
    do_reset();
    while (emif_rst_req[0] && n < 100) begin n++; tick(); end
    n_chk++; if (n != RH) $display("FAIL succ_hold: got %0d cycles want %0d", n, RH); else n_pass++;
    repeat (10) tick();
    n_chk++; if (ch_state[1:0] !== 2'd1 || ch_ready[0] !== 1'b0) $display("FAIL succ_pre: got state %0d ready %b want 1/0", ch_state[1:0], ch_ready[0]); else n_pass++;
    cal_success[0] = 1'b1; tick();
    n_chk++; if (ch_ready[0] !== 1'b1 || ch_state[1:0] !== 2'd2) $display("FAIL succ_ready: got ready %b state %0d want 1/2", ch_ready[0], ch_state[1:0]); else n_pass++;
    cal_success = '0;
  endtask

  task automatic test_cal_fail();
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      wait_st(1, 1, 40, "fail_wait");
      cal_fail[1] = 1'b1; tick(); cal_fail[1] = 1'b0;
      if (k < 3) begin
        n_chk++; if (retry_cnt[3:2] !== 2'(k) || ch_state[3:2] !== 2'd0) $display("FAIL fail_retry%0d: got retry %0d state %0d want %0d/0", k, retry_cnt[3:2], ch_state[3:2], k); else n_pass++;
      end
    end
    n_chk++; if (ch_state[3:2] !== 2'd3 || ch_error[1] !== 1'b1) $display("FAIL fail_error: got state %0d err %b want 3/1", ch_state[3:2], ch_error[1]); else n_pass++;
    n_chk++; if (any_error !== 1'b1 || emif_rst_req[1] !== 1'b0) $display("FAIL fail_flags: got any_error %b rst_req %b want 1/0", any_error, emif_rst_req[1]); else n_pass++;
    n_chk++; if (retry_cnt[3:2] !== 2'd2) $display("FAIL fail_retry_sat: got %0d want 2", retry_cnt[3:2]); else n_pass++;
    cal_success[1] = 1'b1; repeat (20) tick();
    n_chk++; if (ch_state[3:2] !== 2'd3) $display("FAIL fail_sticky: got state %0d want 3", ch_state[3:2]); else n_pass++;
    cal_success = '0;
  endtask

  task automatic test_timeout();
    do_reset();
`ifdef EMIF_INIT_TIMEOUT_EN
    for (int k = 1; k <= 3; k++) begin
      int n = 0;
      wait_st(0, 1, 40, "to_wait");
      while (ch_state[1:0] == 2'd1 && n < 300) begin n++; tick(); end
      n_chk++; if (n != CT) $display("FAIL to_len%0d: got %0d cycles want %0d", k, n, CT); else n_pass++;
      n_chk++; if (ch_state[1:0] !== (k < 3 ? 2'd0 : 2'd3)) $display("FAIL to_state%0d: got %0d want %0d", k, ch_state[1:0], k < 3 ? 0 : 3); else n_pass++;
    end
`else
    wait_st(0, 1, 40, "to_wait");
    repeat (300) tick();
    n_chk++; if (ch_state[1:0] !== 2'd1 || retry_cnt[1:0] !== 2'd0) $display("FAIL no_timeout: got state %0d retry %0d want 1/0", ch_state[1:0], retry_cnt[1:0]); else n_pass++;
`endif
  endtask

  task automatic test_both();
    do_reset();
    wait_st(0, 1, 40, "both_wait");
    cal_success[0] = 1'b1; cal_fail[0] = 1'b1; tick(); cal_success[0] = 1'b0; cal_fail[0] = 1'b0;
    n_chk++; if (ch_state[1:0] !== 2'd0 || retry_cnt[1:0] !== 2'd1 || ch_ready[0] !== 1'b0) $display("FAIL both: got state %0d retry %0d ready %b want 0/1/0", ch_state[1:0], retry_cnt[1:0], ch_ready[0]); else n_pass++;
  endtask

  task automatic test_reinit();
    int n = 0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      wait_st(2, 1, 40, "reinit_wait");
      cal_fail[2] = 1'b1; tick(); cal_fail[2] = 1'b0;
    end
    n_chk++; if (ch_state[5:4] !== 2'd3) $display("FAIL reinit_err: got %0d want 3", ch_state[5:4]); else n_pass++;
    sw_reinit[2] = 1'b1; tick(); sw_reinit[2] = 1'b0;
    n_chk++; if (ch_state[5:4] !== 2'd0 || retry_cnt[5:4] !== 2'd0) $display("FAIL reinit_err_clr: got state %0d retry %0d want 0/0", ch_state[5:4], retry_cnt[5:4]); else n_pass++;
    while (emif_rst_req[2] && n < 100) begin n++; tick(); end
    n_chk++; if (n != RH) $display("FAIL reinit_hold1: got %0d cycles want %0d", n, RH); else n_pass++;
    cal_fail[2] = 1'b1; tick(); cal_fail[2] = 1'b0;
    wait_st(2, 1, 40, "reinit_wait2");
    cal_success[2] = 1'b1; tick();
    n_chk++; if (ch_ready[2] !== 1'b1 || retry_cnt[5:4] !== 2'd1) $display("FAIL reinit_ready: got ready %b retry %0d want 1/1", ch_ready[2], retry_cnt[5:4]); else n_pass++;
    sw_reinit[2] = 1'b1; tick(); sw_reinit[2] = 1'b0;
    n_chk++; if (ch_state[5:4] !== 2'd0 || retry_cnt[5:4] !== 2'd0) $display("FAIL reinit_rdy_clr: got state %0d retry %0d want 0/0", ch_state[5:4], retry_cnt[5:4]); else n_pass++;
    n = 0;
    while (emif_rst_req[2] && n < 100) begin n++; tick(); end
    n_chk++; if (n != RH) $display("FAIL reinit_hold2: got %0d cycles want %0d", n, RH); else n_pass++;
    cal_success = '0;
  endtask

  task automatic test_all_ready();
    int ord[N];
    for (int i = 0; i < N; i++) ord[i] = i;
    for (int i = N - 1; i > 0; i--) begin
      int j, t;
      j = $urandom_range(0, i); t = ord[i]; ord[i] = ord[j]; ord[j] = t;
    end
    do_reset();
    wait_st(3, 1, 40, "all_wait");
    for (int k = 0; k < N; k++) begin
      repeat ($urandom_range(3, 9)) tick();
      cal_success[ord[k]] = 1'b1; tick();
      n_chk++; if (all_ready !== (k == N - 1) || ch_ready[ord[k]] !== 1'b1) $display("FAIL all_ready_step%0d: got all %b ch%0d %b want %b/1", k, all_ready, ord[k], ch_ready[ord[k]], k == N - 1); else n_pass++;
    end
    cal_success[3] = 1'b0; tick();
    n_chk++; if (all_ready !== 1'b0 || ch_state[7:6] !== 2'd0) $display("FAIL all_ready_drop: got all %b state3 %0d want 0/0", all_ready, ch_state[7:6]); else n_pass++;
    cal_success = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] e_rr, e_rdy, e_err;
    logic [2*N-1:0] e_st, e_rc;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 15) == 0) cal_success[c] = ~cal_success[c];
        cal_fail[c] = $urandom_range(0, 29) == 0;
        sw_reinit[c] = $urandom_range(0, 149) == 0;
      end
      reset = $urandom_range(0, 399) == 0;
      tick();
      for (int c = 0; c < N; c++) begin
        e_rr[c] = m_ph[c] == 0; e_rdy[c] = m_ph[c] == 2; e_err[c] = m_ph[c] == 3;
        e_st[2*c +: 2] = 2'(m_ph[c]); e_rc[2*c +: 2] = 2'(m_try[c]);
      end
      n_chk++; if (emif_rst_req !== e_rr) $display("FAIL rand_rst_req @%0d: got %h want %h", i, emif_rst_req, e_rr); else n_pass++;
      n_chk++; if (ch_ready !== e_rdy) $display("FAIL rand_ready @%0d: got %h want %h", i, ch_ready, e_rdy); else n_pass++;
      n_chk++; if (ch_error !== e_err) $display("FAIL rand_error @%0d: got %h want %h", i, ch_error, e_err); else n_pass++;
      n_chk++; if (ch_state !== e_st) $display("FAIL rand_state @%0d: got %h want %h", i, ch_state, e_st); else n_pass++;
      n_chk++; if (retry_cnt !== e_rc) $display("FAIL rand_retry @%0d: got %h want %h", i, retry_cnt, e_rc); else n_pass++;
      n_chk++; if (all_ready !== &e_rdy) $display("FAIL rand_all_ready @%0d: got %b want %b", i, all_ready, &e_rdy); else n_pass++;
      n_chk++; if (any_error !== |e_err) $display("FAIL rand_any_error @%0d: got %b want %b", i, any_error, |e_err); else n_pass++;
    end
    reset = 1'b0; cal_success = '0; cal_fail = '0; sw_reinit = '0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_cal_success();
    test_cal_fail();
    test_timeout();
    test_both();
    test_reinit();
    test_all_ready();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/emif_init_seq.md
EMIF_INIT_SEQ -- requirements
Module: emif_init_seq

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4: number of memory channels sequenced.
REQ-002 The block SHALL have parameter RESET_HOLD, default 16: cycles emif_rst_req is held asserted per reset attempt.
REQ-003 The block SHALL have parameter CAL_TIMEOUT, default 1000000: cycles allowed in WAIT_CAL before declaring failure.
REQ-004 The block SHALL have parameter MAX_RETRY, default 2: re-reset attempts after a failure before entering ERROR.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port cal_success, input, NUM_CH bits: per-channel EMIF calibration-pass level.
REQ-009 The block SHALL have port cal_fail, input, NUM_CH bits: per-channel EMIF calibration-fail level.
REQ-010 The block SHALL have port sw_reinit, input, NUM_CH bits: per-channel single-cycle re-initialise request from CSR.
REQ-011 The block SHALL have port emif_rst_req, output, NUM_CH bits: per-channel EMIF reset request, active-high.
REQ-012 The block SHALL have port ch_ready, output, NUM_CH bits: channel calibrated and usable by the AFU.
REQ-013 The block SHALL have port ch_error, output, NUM_CH bits: channel failed permanently.
REQ-014 The block SHALL have port ch_state, output, 2*NUM_CH bits: per-channel state encoding, for CSR.
REQ-015 The block SHALL have port retry_cnt, output, 2*NUM_CH bits: per-channel retries used, for CSR.
REQ-016 The block SHALL have port all_ready, output, 1 bit: AND of ch_ready.
REQ-017 The block SHALL have port any_error, output, 1 bit: OR of ch_error.

Function
REQ-018 Each channel SHALL run an independent FSM with states RST_HOLD=0, WAIT_CAL=1, READY=2 and ERROR=3.
REQ-019 In RST_HOLD, emif_rst_req[i] SHALL be 1 and a hold counter SHALL count up, moving to WAIT_CAL after exactly RESET_HOLD cycles.
REQ-020 In WAIT_CAL, emif_rst_req[i] SHALL be 0 and the state SHALL change on the following conditions:
- cal_fail[i] or timeout, with retry_cnt < MAX_RETRY: increment retry_cnt and go to RST_HOLD.
- cal_fail[i] or timeout, with retry_cnt == MAX_RETRY: go to ERROR.
- otherwise cal_success[i]: go to READY.
REQ-021 If cal_success and cal_fail are both high in the same cycle, fail SHALL win.
REQ-022 If cal_success is high in the same cycle that the timeout expires, success SHALL win.
REQ-023 In READY, ch_ready[i] SHALL be 1, and deassertion of cal_success[i] SHALL cause a transition to RST_HOLD with retry_cnt cleared.
REQ-024 In ERROR, ch_error[i] SHALL be 1 and the FSM SHALL stay in ERROR until sw_reinit[i].
REQ-025 sw_reinit[i] in any state SHALL force RST_HOLD, clear retry_cnt[i], clear the counters, and take priority over all other conditions.
REQ-026 All outputs SHALL be registered and reflect the new state in the cycle after the transition edge.
REQ-027 all_ready and any_error SHALL be combinational reductions of the registered ch_ready and ch_error.
REQ-028 retry_cnt SHALL saturate and never wrap.
REQ-029 Counters SHALL be sized with $clog2 of their limit, and the hold and timeout counters SHALL be cleared on every state entry.

Reset
REQ-030 On reset, every channel SHALL be in RST_HOLD with counters 0, retry_cnt 0, emif_rst_req all 1, and ch_ready, ch_error, all_ready and any_error all 0.
REQ-031 Reset asserted mid-sequence SHALL abort the sequence and restart from RST_HOLD with a full RESET_HOLD period after reset deasserts.

Configuration
REQ-032 With EMIF_INIT_TIMEOUT_EN defined, the WAIT_CAL timeout counter SHALL be present and expiry SHALL be treated as cal_fail.
REQ-033 Without EMIF_INIT_TIMEOUT_EN, no timeout counter SHALL exist and WAIT_CAL SHALL wait indefinitely for cal_success or cal_fail, making CAL_TIMEOUT unused.

Structure
REQ-034 The state enum emif_init_state_t and the state encoding widths SHALL be placed in the shared package mem_init_pkg.
REQ-035 The per-channel FSM SHALL be implemented in sub-module emif_ch_init_fsm, instantiated NUM_CH times in a generate loop, with the top level performing only the reductions.

Verification
REQ-036 The bench SHALL cover the following directed scenarios, all with RESET_HOLD=16, CAL_TIMEOUT=100 and MAX_RETRY=2:
- Reset release, then cal_success[0] rising 10 cycles after WAIT_CAL entry -> emif_rst_req[0]=1 for exactly 16 cycles; ch_ready[0]=1 on the next cycle.
- cal_fail[1] pulsed in WAIT_CAL three times -> retry_cnt 1, then 2, then ERROR; ch_error[1]=1, any_error=1, emif_rst_req[1]=0.
- TIMEOUT_EN defined and no calibration response -> WAIT_CAL exits after 100 cycles into RST_HOLD; after the third timeout the channel is in ERROR.
- cal_success and cal_fail high together in WAIT_CAL -> retry path taken, not READY.
- sw_reinit[2] while in ERROR, and again while in READY -> RST_HOLD next cycle with retry_cnt 0; a 16-cycle reset hold repeats.
- All 4 channels pass at staggered times -> all_ready=1 only after the last channel is ready; dropping cal_success[3] -> all_ready=0 and channel 3 returns to RST_HOLD.
